// File: rtl/y86_pkg.sv
// Shared Y86-64 decode definitions: icodes, register IDs, bundle layouts and
// the nop bundle loaded into the E register on reset or bubble.
package y86_pkg;

    localparam int XLEN = 64;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RSP   = 4'h4;

    // decode_reg layout
    localparam int D_W          = 145;
    localparam int D_IMEM_ERR   = 144;
    localparam int D_ICODE_LSB  = 140;
    localparam int D_IFUN_LSB   = 136;
    localparam int D_RA_LSB     = 132;
    localparam int D_RB_LSB     = 128;
    localparam int D_VALC_LSB   = 64;
    localparam int D_VALP_LSB   = 0;

    // execute_reg layout
    localparam int E_W          = 217;
    localparam int E_STAT_ERR   = 216;
    localparam int E_ICODE_LSB  = 212;
    localparam int E_IFUN_LSB   = 208;
    localparam int E_VALC_LSB   = 144;
    localparam int E_VALA_LSB   = 80;
    localparam int E_VALB_LSB   = 16;
    localparam int E_DSTE_LSB   = 12;
    localparam int E_DSTM_LSB   = 8;
    localparam int E_SRCA_LSB   = 4;
    localparam int E_SRCB_LSB   = 0;

    typedef struct packed {
        logic            stat_err;
        logic [3:0]      icode;
        logic [3:0]      ifun;
        logic [XLEN-1:0] valc;
        logic [XLEN-1:0] vala;
        logic [XLEN-1:0] valb;
        logic [3:0]      dste;
        logic [3:0]      dstm;
        logic [3:0]      srca;
        logic [3:0]      srcb;
    } e_bundle_t;

    localparam e_bundle_t E_NOP = '{
        stat_err: 1'b0, icode: I_NOP, ifun: 4'h0,
        valc: '0, vala: '0, valb: '0,
        dste: RNONE, dstm: RNONE, srca: RNONE, srcb: RNONE
    };

endpackage

// File: rtl/y86_regfile.sv
// 15-entry register file: two combinational read ports (ID F reads 0) and
// two write ports where the M port overrides E on a same-register write.
module y86_regfile
    import y86_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int NREG   = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        src_a,
    input  logic [3:0]        src_b,
    output logic [DATA_W-1:0] val_a,
    output logic [DATA_W-1:0] val_b,
    input  logic [3:0]        dst_e,
    input  logic [DATA_W-1:0] val_e,
    input  logic [3:0]        dst_m,
    input  logic [DATA_W-1:0] val_m
);

    logic [DATA_W-1:0] regs [NREG];

    assign val_a = (32'(src_a) < NREG) ? regs[src_a] : '0;
    assign val_b = (32'(src_b) < NREG) ? regs[src_b] : '0;

    // M write is issued last so it wins when both ports target one register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (dst_e != RNONE) regs[dst_e] <= val_e;
            if (dst_m != RNONE) regs[dst_m] <= val_m;
        end
    end

endmodule

// File: rtl/decode_writeback.sv
// Y86-64 decode stage with register-file writeback port and E pipeline register.
// Optional macro DECODE_FWD_EN enables operand forwarding; otherwise hazards stall.
module decode_writeback
    import y86_pkg::*;
#(
    parameter int DATA_W = XLEN,
    parameter int NREG   = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [D_W-1:0]    decode_reg,
    input  logic              E_bubble,
    input  logic [3:0]        e_dstE,
    input  logic [DATA_W-1:0] e_valE,
    input  logic [3:0]        M_dstE,
    input  logic [DATA_W-1:0] M_valE,
    input  logic [3:0]        M_dstM,
    input  logic [DATA_W-1:0] m_valM,
    input  logic [3:0]        W_dstE,
    input  logic [DATA_W-1:0] W_valE,
    input  logic [3:0]        W_dstM,
    input  logic [DATA_W-1:0] W_valM,
    output logic [E_W-1:0]    execute_reg,
    output logic [3:0]        d_srcA,
    output logic [3:0]        d_srcB,
    output logic              load_use
);

    logic              imem_err;
    logic [3:0]        icode, ifun, ra, rb;
    logic [DATA_W-1:0] valc, valp;
    logic              illegal;
    logic [3:0]        dste, dstm;
    logic [DATA_W-1:0] rf_a, rf_b, vala, valb;
    e_bundle_t         e_q;

    assign imem_err = decode_reg[D_IMEM_ERR];
    assign icode    = decode_reg[D_ICODE_LSB +: 4];
    assign ifun     = decode_reg[D_IFUN_LSB +: 4];
    assign ra       = decode_reg[D_RA_LSB +: 4];
    assign rb       = decode_reg[D_RB_LSB +: 4];
    assign valc     = decode_reg[D_VALC_LSB +: DATA_W];
    assign valp     = decode_reg[D_VALP_LSB +: DATA_W];
    assign illegal  = (icode > I_POPQ);

    always_comb begin
        d_srcA = RNONE;
        d_srcB = RNONE;
        dste   = RNONE;
        dstm   = RNONE;
        case (icode)
            I_RRMOVQ: begin d_srcA = ra;  dste = rb; end
            I_IRMOVQ: begin dste = rb; end
            I_RMMOVQ: begin d_srcA = ra;  d_srcB = rb; end
            I_MRMOVQ: begin d_srcB = rb;  dstm = ra; end
            I_OPQ:    begin d_srcA = ra;  d_srcB = rb;  dste = rb; end
            I_CALL:   begin d_srcB = RSP; dste = RSP; end
            I_RET:    begin d_srcA = RSP; d_srcB = RSP; dste = RSP; end
            I_PUSHQ:  begin d_srcA = ra;  d_srcB = RSP; dste = RSP; end
            I_POPQ:   begin d_srcA = RSP; d_srcB = RSP; dste = RSP; dstm = ra; end
            default:  ;
        endcase
    end

    y86_regfile #(
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .src_a (d_srcA),
        .src_b (d_srcB),
        .val_a (rf_a),
        .val_b (rf_b),
        .dst_e (W_dstE),
        .val_e (W_valE),
        .dst_m (W_dstM),
        .val_m (W_valM)
    );

`ifdef DECODE_FWD_EN
    // Youngest producer wins; within M, load data beats the ALU result
    function automatic logic [DATA_W-1:0] select_src(input logic [3:0] src,
                                                     input logic [DATA_W-1:0] rf_val);
        if (src == RNONE)  return '0;
        if (src == e_dstE) return e_valE;
        if (src == M_dstM) return m_valM;
        if (src == M_dstE) return M_valE;
        if (src == W_dstM) return W_valM;
        if (src == W_dstE) return W_valE;
        return rf_val;
    endfunction

    assign load_use = ((e_q.icode == I_MRMOVQ) || (e_q.icode == I_POPQ)) &&
                      (e_q.dstm != RNONE) &&
                      ((e_q.dstm == d_srcA) || (e_q.dstm == d_srcB));
`else
    function automatic logic [DATA_W-1:0] select_src(input logic [3:0] src,
                                                     input logic [DATA_W-1:0] rf_val);
        return (src == RNONE) ? '0 : rf_val;
    endfunction

    // Any in-flight writer of a source register stalls decode until it lands
    function automatic logic pending(input logic [3:0] src);
        return (src != RNONE) &&
               ((src == e_q.dste) || (src == e_q.dstm) || (src == M_dstE) ||
                (src == M_dstM)   || (src == W_dstE)   || (src == W_dstM));
    endfunction

    assign load_use = pending(d_srcA) || pending(d_srcB);

    logic unused_fwd;
    assign unused_fwd = ^{e_dstE, e_valE, M_valE, m_valM};
`endif

    assign vala = ((icode == I_CALL) || (icode == I_JXX)) ? valp : select_src(d_srcA, rf_a);
    assign valb = select_src(d_srcB, rf_b);

    // ---- D -> E pipeline register ----
    always_ff @(posedge clk) begin
        if (!rst_n || E_bubble) begin
            e_q <= E_NOP;
        end else if (illegal) begin
            e_q <= '{stat_err: 1'b1, icode: icode, ifun: ifun, valc: valc,
                     vala: vala, valb: valb, dste: RNONE, dstm: RNONE,
                     srca: RNONE, srcb: RNONE};
        end else begin
            e_q <= '{stat_err: imem_err, icode: icode, ifun: ifun, valc: valc,
                     vala: vala, valb: valb, dste: dste, dstm: dstm,
                     srca: d_srcA, srcb: d_srcB};
        end
    end

    assign execute_reg = e_q;

endmodule

// File: tb/tb_decode_writeback.sv
// Directed bench for decode_writeback; expectations follow the build
// (DECODE_FWD_EN defined or not).
module tb_decode_writeback;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [144:0] decode_reg;
    logic         E_bubble;
    logic [3:0]   e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
    logic [63:0]  e_valE, M_valE, m_valM, W_valE, W_valM;
    logic [216:0] execute_reg;
    logic [3:0]   d_srcA, d_srcB;
    logic         load_use;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decode_writeback dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .decode_reg  (decode_reg),
        .E_bubble    (E_bubble),
        .e_dstE      (e_dstE),
        .e_valE      (e_valE),
        .M_dstE      (M_dstE),
        .M_valE      (M_valE),
        .M_dstM      (M_dstM),
        .m_valM      (m_valM),
        .W_dstE      (W_dstE),
        .W_valE      (W_valE),
        .W_dstM      (W_dstM),
        .W_valM      (W_valM),
        .execute_reg (execute_reg),
        .d_srcA      (d_srcA),
        .d_srcB      (d_srcB),
        .load_use    (load_use)
    );

    wire        x_stat  = execute_reg[216];
    wire [3:0]  x_icode = execute_reg[215:212];
    wire [63:0] x_valc  = execute_reg[207:144];
    wire [63:0] x_vala  = execute_reg[143:80];
    wire [63:0] x_valb  = execute_reg[79:16];
    wire [3:0]  x_dste  = execute_reg[15:12];
    wire [3:0]  x_dstm  = execute_reg[11:8];
    wire [3:0]  x_srca  = execute_reg[7:4];
    wire [3:0]  x_srcb  = execute_reg[3:0];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [144:0] mk_d(input logic err, input logic [3:0] ic,
                                          input logic [3:0] ra, input logic [3:0] rb,
                                          input logic [63:0] vc, input logic [63:0] vp);
        return {err, ic, 4'h0, ra, rb, vc, vp};
    endfunction

    initial begin
        rst_n = 1'b0;
        E_bubble = 1'b0;
        decode_reg = mk_d(1'b0, 4'h3, 4'hF, 4'h7, 64'h99, 64'h0);
        e_dstE = 4'hF; M_dstE = 4'hF; M_dstM = 4'hF; W_dstE = 4'hF; W_dstM = 4'hF;
        e_valE = '0; M_valE = '0; m_valM = '0; W_valE = '0; W_valM = '0;
        step();
        step();
        check("rst_icode", x_icode, 64'h1);
        check("rst_dste", x_dste, 64'hF);
        check("rst_srca", x_srca, 64'hF);
        check("rst_vala", x_vala, 64'h0);
        check("rst_valc", x_valc, 64'h0);
        check("rst_stat", x_stat, 64'h0);
        rst_n = 1'b1;

        // irmovq $0x10, %rdx
        decode_reg = mk_d(1'b0, 4'h3, 4'hF, 4'h2, 64'h10, 64'h1A);
        step();
        check("irm_icode", x_icode, 64'h3);
        check("irm_dste", x_dste, 64'h2);
        check("irm_dstm", x_dstm, 64'hF);
        check("irm_srca", x_srca, 64'hF);
        check("irm_srcb", x_srcb, 64'hF);
        check("irm_valc", x_valc, 64'h10);

        // write R3 = 0x55, then rrmovq %rbx, %rbp
        W_dstE = 4'h3; W_valE = 64'h55;
        decode_reg = mk_d(1'b0, 4'h1, 4'hF, 4'hF, 64'h0, 64'h0);
        step();
        W_dstE = 4'hF;
        decode_reg = mk_d(1'b0, 4'h2, 4'h3, 4'h5, 64'h0, 64'h0);
        #1;
        check("rr_dsrca", d_srcA, 64'h3);
        check("rr_lu", load_use, 64'h0);
        step();
        check("rr_vala", x_vala, 64'h55);
        check("rr_dste", x_dste, 64'h5);
        check("rr_srcb", x_srcb, 64'hF);

        // opq %rbx, %rsi with execute and writeback both producing R3
        e_dstE = 4'h3; e_valE = 64'hAA; W_dstE = 4'h3; W_valE = 64'h11;
        decode_reg = mk_d(1'b0, 4'h6, 4'h3, 4'h6, 64'h0, 64'h0);
        #1;
`ifdef DECODE_FWD_EN
        check("op_lu", load_use, 64'h0);
        step();
        check("op_vala_fwd", x_vala, 64'hAA);
`else
        check("op_lu", load_use, 64'h1);
        step();
        check("op_vala_rf", x_vala, 64'h55);
`endif
        check("op_valb", x_valb, 64'h0);
        check("op_dste", x_dste, 64'h6);
        e_dstE = 4'hF; W_dstE = 4'hF;

        // mrmovq 8(%rdx), %rcx then dependent opq -> load/use, then bubble
        decode_reg = mk_d(1'b0, 4'h5, 4'h1, 4'h2, 64'h8, 64'h0);
        step();
        check("mr_icode", x_icode, 64'h5);
        check("mr_dstm", x_dstm, 64'h1);
        check("mr_srcb", x_srcb, 64'h2);
        check("mr_dste", x_dste, 64'hF);
        decode_reg = mk_d(1'b0, 4'h6, 4'h1, 4'h2, 64'h0, 64'h0);
        #1;
        check("lu_flag", load_use, 64'h1);
        check("lu_dsrcb", d_srcB, 64'h2);
        E_bubble = 1'b1;
        step();
        E_bubble = 1'b0;
        check("bub_icode", x_icode, 64'h1);
        check("bub_dste", x_dste, 64'hF);
        check("bub_srca", x_srca, 64'hF);
        check("bub_vala", x_vala, 64'h0);

        // both write ports hit R4: M value wins; then popq %rdi
        W_dstE = 4'h4; W_valE = 64'h8; W_dstM = 4'h4; W_valM = 64'h20;
        decode_reg = mk_d(1'b0, 4'h1, 4'hF, 4'hF, 64'h0, 64'h0);
        step();
        W_dstE = 4'hF; W_dstM = 4'hF;
        decode_reg = mk_d(1'b0, 4'hB, 4'h7, 4'hF, 64'h0, 64'h0);
        #1;
        check("pop_lu", load_use, 64'h0);
        step();
        check("pop_srca", x_srca, 64'h4);
        check("pop_srcb", x_srcb, 64'h4);
        check("pop_dste", x_dste, 64'h4);
        check("pop_dstm", x_dstm, 64'h7);
        check("pop_vala", x_vala, 64'h20);
        check("pop_valb", x_valb, 64'h20);

        // call 0x100, return address 0x40
        decode_reg = mk_d(1'b0, 4'h8, 4'hF, 4'hF, 64'h100, 64'h40);
        #1;
`ifdef DECODE_FWD_EN
        check("call_lu", load_use, 64'h0);
`else
        check("call_lu", load_use, 64'h1);
`endif
        step();
        check("call_vala", x_vala, 64'h40);
        check("call_srcb", x_srcb, 64'h4);
        check("call_dste", x_dste, 64'h4);
        check("call_srca", x_srca, 64'hF);
        check("call_valc", x_valc, 64'h100);

        // illegal icode 0xC, then imem error on a nop
        decode_reg = mk_d(1'b0, 4'hC, 4'h1, 4'h2, 64'h0, 64'h0);
        step();
        check("ill_stat", x_stat, 64'h1);
        check("ill_icode", x_icode, 64'hC);
        check("ill_srca", x_srca, 64'hF);
        check("ill_dste", x_dste, 64'hF);
        decode_reg = mk_d(1'b1, 4'h1, 4'hF, 4'hF, 64'h0, 64'h0);
        step();
        check("imem_stat", x_stat, 64'h1);
        decode_reg = mk_d(1'b0, 4'h1, 4'hF, 4'hF, 64'h0, 64'h0);
        step();
        check("ok_stat", x_stat, 64'h0);

        // reset mid-stream discards a pending write and clears registers
        W_dstE = 4'h2; W_valE = 64'h77;
        decode_reg = mk_d(1'b0, 4'h3, 4'hF, 4'h2, 64'h33, 64'h0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        W_dstE = 4'hF;
        check("mrst_icode", x_icode, 64'h1);
        check("mrst_dste", x_dste, 64'hF);
        decode_reg = mk_d(1'b0, 4'h6, 4'h2, 4'h4, 64'h0, 64'h0);
        step();
        check("mrst_r2", x_vala, 64'h0);
        check("mrst_r4", x_valb, 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
